// File: rtl/load_pkg.sv
// load_pkg: load-type codes shared by the load unit and its users.
package load_pkg;
  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_H    = 3'b010,
    LD_W    = 3'b011,
    LD_BU   = 3'b100,
    LD_HU   = 3'b101
  } load_kind_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: sign/zero extension of a selected byte or halfword to 32 bits.
module load_extend (
  input  logic [15:0] field,
  input  logic        half,
  input  logic        sgn,
  output logic [31:0] ext
);
  always_comb ext = half ? {{16{sgn & field[15]}}, field} : {{24{sgn & field[7]}}, field[7:0]};
endmodule

// File: rtl/load_unit.sv
// load_unit: load-data alignment/extension with a registered result.
// Optional misalignment flag enabled by LOAD_MISALIGN_EN.
module load_unit
  import load_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_data,
  input  logic [1:0]  addr_rem,
  input  logic [31:0] alu_result,
  input  logic [2:0]  info_load,
  output logic [31:0] data
`ifdef LOAD_MISALIGN_EN
  ,
  output logic        misaligned
`endif
);
  load_kind_t  kind;
  logic [31:0] shifted, ext, next;
  logic        is_byte, is_half, sgn;
  logic        unused;
  assign kind    = load_kind_t'(info_load);
  // Shifting the word down by the offset puts the wanted field in the low bits.
  assign shifted = addr_data >> {addr_rem, 3'b000};
  assign is_byte = kind == LD_B || kind == LD_BU;
  assign is_half = (kind == LD_H || kind == LD_HU) && addr_rem != 2'b11;
  assign sgn     = kind == LD_B || kind == LD_H;
  assign next    = kind == LD_W ? addr_data : (is_byte || is_half) ? ext : '0;
  assign unused  = ^{alu_result, shifted[31:16]};
  load_extend u_extend (
    .field(shifted[15:0]),
    .half (is_half),
    .sgn  (sgn),
    .ext  (ext)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data <= '0;
    else data <= next;
`ifdef LOAD_MISALIGN_EN
  logic mis_next;
  assign mis_next = ((kind == LD_H || kind == LD_HU) && alu_result[0]) ||
                    (kind == LD_W && alu_result[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misaligned <= 1'b0;
    else misaligned <= mis_next;
`endif
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: randomized + directed scoreboard bench for load_unit.
module tb_load_unit;
  import load_pkg::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] addr_data = 0, alu_result = 0;
  logic [1:0]  addr_rem = 0;
  logic [2:0]  info_load = 0;
  logic [31:0] data;
  logic        mis_out;
  typedef struct { logic [31:0] d; logic m; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  load_unit dut (
    .clk(clk), .rst_n(rst_n), .addr_data(addr_data), .addr_rem(addr_rem),
    .alu_result(alu_result), .info_load(info_load), .data(data)
`ifdef LOAD_MISALIGN_EN
    , .misaligned(mis_out)
`endif
  );
`ifndef LOAD_MISALIGN_EN
  assign mis_out = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data(logic [31:0] d, logic [1:0] r, logic [2:0] k);
    logic [31:0] b, h;
    b = (d >> (8 * r)) & 32'hff;
    h = (d >> (8 * r)) & 32'hffff;
    case (k)
      LD_B:    return b >= 128 ? b - 32'd256 : b;
      LD_BU:   return b;
      LD_H:    return r == 3 ? 32'h0 : (h >= 32768 ? h - 32'd65536 : h);
      LD_HU:   return r == 3 ? 32'h0 : h;
      LD_W:    return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_mis(logic [31:0] a, logic [2:0] k);
    if (k == LD_H || k == LD_HU) return a % 2 != 0;
    if (k == LD_W) return a % 4 != 0;
    return 1'b0;
  endfunction

  task automatic issue(logic [31:0] d, logic [31:0] a, logic [2:0] k);
    exp_t e;
    @(negedge clk);
    addr_data = d; alu_result = a; addr_rem = a[1:0]; info_load = k;
    e.d = model_data(d, a[1:0], k);
    e.m = model_mis(a, k);
    q.push_back(e);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("data", data, e.d);
`ifdef LOAD_MISALIGN_EN
      chk("misaligned", {31'b0, mis_out}, {31'b0, e.m});
`endif
    end
  end

  initial begin
    logic [31:0] w;
    w = 32'h80FF7F01;
    addr_data = $urandom; alu_result = 32'h1003; addr_rem = 2'b11; info_load = LD_W;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_data", data, 32'h0);
    chk("reset_mis", {31'b0, mis_out}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < 4; r++) issue(w, 32'h1000 + r, LD_B);
    issue(w, 32'h1003, LD_BU);
    issue(w, 32'h1002, LD_H);
    issue(w, 32'h1001, LD_HU);
    issue(w, 32'h1003, LD_H);
    issue(w, 32'h1000, LD_W);
    issue(w, 32'h1002, LD_W);
    issue(w, 32'h1000, LD_NONE);
    issue(w, 32'h1001, 3'b111);
    issue(w, 32'h1002, 3'b110);
    issue($urandom, 32'h1002, LD_W);
    issue($urandom, 32'h1002, LD_H);
    issue($urandom, 32'h1001, LD_HU);
    issue($urandom, 32'h1003, LD_B);
    for (int i = 0; i < 8; i++) issue($urandom, $urandom, i % 2 ? LD_W : LD_B);
    for (int i = 0; i < 300; i++) issue($urandom, $urandom, 3'($urandom_range(0, 7)));
    // mid-stream reset: the word load lands, then reset wipes it asynchronously
    issue(32'hDEADBEEF, 32'h2000, LD_W);
    issue(32'h12345678, 32'h2001, LD_B);
    #2;
    rst_n = 0;
    q.delete();
    #1;
    chk("async_reset_data", data, 32'h0);
    chk("async_reset_mis", {31'b0, mis_out}, 32'h0);
    @(posedge clk);
    #1;
    chk("held_reset_data", data, 32'h0);
    @(negedge clk);
    rst_n = 1;
    issue(w, 32'h1003, LD_B);
    for (int i = 0; i < 20; i++) issue($urandom, $urandom, 3'($urandom_range(0, 7)));
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
